// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded from Addr[3:2]
//   - transmitter FSM state encoding
//   - CTRL / STATUS bit positions
//   - effDiv(): maps a programmed divisor of 0 onto 1
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    // Register offsets (word index within the device window)
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    // STATUS bit positions; FIFO count occupies [8:4]
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_MSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } txState_e;

    // A divisor of zero would never let the baud counter expire; run it as 1.
    function automatic logic [15:0] effDiv(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   push, wrData    - enqueue wrData (ignored when full unless popping too)
//   pop             - dequeue head (ignored when empty)
//   flush           - discard all entries; wins over push/pop
//   rdData          - current head entry (valid when !empty)
//   full, empty     - occupancy flags
//   count           - number of stored entries (0..DEPTH)
// DEPTH must be a power of two in 2..16 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wrData,
    output logic [7:0] rdData,
    output logic       full,
    output logic       empty,
    output logic [4:0] count
);

    localparam int         PTR_W     = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [4:0]       cnt;
    logic             doPush;
    logic             doPop;

    assign full   = (cnt == DEPTH_CNT);
    assign empty  = (cnt == 5'd0);
    assign count  = cnt;
    assign rdData = mem[rdPtr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // succeeds when it coincides with a pop.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order; blocking (=) here would
    // create order-dependent simulation and mismatch the synthesized logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= 5'd0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= 5'd0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            cnt <= cnt + 5'(doPush) - 5'(doPop);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, and leaving the data unreset lets
    // it map onto plain RAM/register cells without a reset network.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// ---------------------------------------------------------------------------
// uart_tx_dev
// Memory-mapped 8N1 serial transmitter, a peripheral on the system bridge.
// IRQ is wired to HWInt[2] at the bridge; the bridge provides this device's
// own write/read selects.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   Addr[31:2]  - word address; only Addr[3:2] is decoded
//   WE          - write enable, already qualified by device select
//   Din         - write data
//   Dout        - read data, combinational from Addr[3:2] and register state
//   IRQ         - level interrupt: IE & EN & FIFO empty & FSM idle, registered
//   tx          - serial output, idle high
// Registers: 0 CTRL {IE,EN}, 1 DIV[15:0], 2 DATA (write pushes byte),
//            3 STATUS {count[8:4], OVF, EMPTY, FULL, BUSY}.
// ---------------------------------------------------------------------------
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    // Register file
    logic        ctrlEn;
    logic        ctrlIe;
    logic        ovf;
    logic [15:0] divReg;

    // Datapath / FSM
    txState_e    state;
    txState_e    stateNext;
    logic [15:0] baudCnt;
    logic [15:0] baudCntNext;
    logic [15:0] baudReload;
    logic [2:0]  bitCnt;
    logic [2:0]  bitCntNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic        txNext;
    logic        bitDone;
    logic        popReq;
    logic        flushReq;

    // FIFO interface
    logic [7:0]  fifoData;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [4:0]  fifoCount;

    // Bus decode
    logic        selCtrlWr;
    logic        selDivWr;
    logic        selDataWr;

    // Upper address and data bits are outside this device's decode.
    logic        unusedBits;
    assign unusedBits = &{1'b0, Addr[31:4], Din[31:16]};

    assign selCtrlWr = WE && (Addr[3:2] == REG_CTRL);
    assign selDivWr  = WE && (Addr[3:2] == REG_DIV);
    assign selDataWr = WE && (Addr[3:2] == REG_DATA);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (selDataWr),
        .pop    (popReq),
        .flush  (flushReq),
        .wrData (Din[7:0]),
        .rdData (fifoData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlEn <= 1'b0;
            ctrlIe <= 1'b0;
            divReg <= DIV_RESET;
            ovf    <= 1'b0;
        end else begin
            if (selCtrlWr) begin
                ctrlEn <= Din[CTRL_EN];
                ctrlIe <= Din[CTRL_IE];
            end
            if (selDivWr) divReg <= Din[15:0];
            // A DATA write is dropped only if the FIFO is full and no pop
            // frees a slot in the same cycle.
            if (selCtrlWr)
                ovf <= 1'b0;
            else if (selDataWr && fifoFull && !popReq)
                ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state, baud/bit counters, shifter
    // ------------------------------------------------------------------
    assign baudReload = effDiv(divReg) - 16'd1;
    assign bitDone    = (baudCnt == 16'd0);

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        stateNext   = state;
        baudCntNext = bitDone ? baudReload : baudCnt - 16'd1;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        popReq      = 1'b0;
        flushReq    = 1'b0;

        if (state != ST_IDLE && !ctrlEn) begin
            // EN cleared mid-frame: abandon the frame and drop queued bytes.
            stateNext = ST_IDLE;
            flushReq  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ctrlEn && !fifoEmpty) begin
                        popReq    = 1'b1;
                        shiftNext = fifoData;
                        stateNext = ST_START;
                    end
                end
                ST_START: begin
                    if (bitDone) stateNext = ST_DATA;
                end
                ST_DATA: begin
                    if (bitDone) begin
                        shiftNext  = {1'b0, shiftReg[7:1]};
                        bitCntNext = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) stateNext = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bitDone) begin
                        if (!fifoEmpty) begin
                            // Back-to-back: next start bit follows immediately.
                            popReq    = 1'b1;
                            shiftNext = fifoData;
                            stateNext = ST_START;
                        end else begin
                            stateNext = ST_IDLE;
                        end
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end

        // Both counters restart on every state change; the divisor is thus
        // re-sampled at each bit boundary.
        if (stateNext != state) begin
            baudCntNext = baudReload;
            bitCntNext  = 3'd0;
        end

        // tx is registered from the next state to keep the line glitch-free.
        unique case (stateNext)
            ST_START: txNext = 1'b0;
            ST_DATA:  txNext = shiftNext[0];
            default:  txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baudCnt  <= 16'd0;
            bitCnt   <= 3'd0;
            shiftReg <= 8'd0;
            tx       <= 1'b1;
            IRQ      <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            tx       <= txNext;
            IRQ      <= ctrlIe & ctrlEn & fifoEmpty & (state == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        Dout = 32'd0;
        unique case (Addr[3:2])
            REG_CTRL: begin
                Dout[CTRL_EN] = ctrlEn;
                Dout[CTRL_IE] = ctrlIe;
            end
            REG_DIV:  Dout[15:0] = divReg;
            REG_DATA: Dout = 32'd0;
            REG_STATUS: begin
                Dout[STAT_BUSY]                  = (state != ST_IDLE);
                Dout[STAT_FULL]                  = fifoFull;
                Dout[STAT_EMPTY]                 = fifoEmpty;
                Dout[STAT_OVF]                   = ovf;
                Dout[STAT_CNT_MSB:STAT_CNT_LSB]  = fifoCount;
            end
            default: Dout = 32'd0;
        endcase
    end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped serial transmitter that hangs off the system bridge as a third peripheral beside the two timers, consuming the bridge's device address/write-data/write-enable bus and returning read data plus a level interrupt on a free HWInt line. Software programs a baud divisor, pushes bytes into a small TX FIFO, and the block serialises them as 8N1 frames on `tx`. It raises IRQ when all queued data has been transmitted.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, 2..16.
- `DIV_RESET`, 16'd16: divisor value loaded at reset.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; one clock; all state cleared on assertion.
- `Addr` in [31:2]: word address from the bridge; only `Addr[3:2]` decoded.
- `WE` in 1: write enable, already qualified by the bridge's device select.
- `Din` in 32: write data.
- `Dout` out 32: read data, combinational from `Addr[3:2]` and current register state.
- `IRQ` out 1: level interrupt.
- `tx` out 1: serial line, idle high.

## Operation
- Register map (`Addr[3:2]`):
  - 0 CTRL rw: bit0 EN, bit1 IE, others read 0.
  - 1 DIV rw: bits[15:0] cycles per bit; 0 behaves as 1.
  - 2 DATA wo: write pushes `Din[7:0]`; reads 0.
  - 3 STATUS ro: bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[8:4] FIFO count.
- Any write to CTRL clears OVF. Writes to STATUS are ignored.
- Write to DATA while FULL: byte dropped, OVF set, FIFO unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1; if EN and FIFO not empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for DIV cycles, then DATA.
  - DATA: `tx`=shift[0] for DIV cycles per bit, LSB first, 8 bits, then STOP.
  - STOP: `tx`=1 for DIV cycles; then, if EN and FIFO not empty, pop and go to START (back-to-back), else IDLE.
- Bit counter and baud counter reload on every state change. DIV is sampled at each bit boundary, so a mid-frame DIV write affects the next bit.
- Clearing EN mid-frame aborts the frame:
  - FSM goes to IDLE and `tx`=1 on the next edge.
  - FIFO is flushed; OVF is kept.
- Push and pop in the same cycle leave count unchanged, and both operations take effect. A push while FULL coinciding with a pop succeeds, with no OVF.
- IRQ = IE & EN & EMPTY & (state==IDLE), registered so that it updates one edge after the condition.

## Timing
- Reset values:
  - `tx`=1, `IRQ`=0, CTRL=0, DIV=DIV_RESET, FIFO empty, OVF=0, FSM IDLE.
  - `Dout` reflects these values immediately.
- Register writes take effect at the rising edge where WE=1.
- If DATA is written at edge N with EN set and FSM IDLE: START is entered at edge N+1, and `tx` falls after N+1.
- Frame length is exactly 10×DIV cycles. Back-to-back frames have no idle gap.
- Last stop bit ends at edge M with an empty FIFO: FSM is IDLE after M, and IRQ rises after M+1 when IE=1.
- `reset` asserted mid-frame forces `tx`=1 asynchronously, with no partial stop bit.

## Structure
- Shared package `uart_tx_pkg` holds:
  - register offsets (CTRL=2'd0, DIV=2'd1, DATA=2'd2, STATUS=2'd3);
  - FSM state encoding;
  - STATUS/CTRL bit positions.
- Sub-module `tx_fifo`: synchronous FIFO of width 8 and depth FIFO_DEPTH, with push/pop/flush, full/empty/count, and async reset.
- Top level holds the register file, baud counter, bit counter, shifter and FSM.
- Top-level integration: tie `IRQ` to HWInt[2] and shift `interrupt` to HWInt[3]; the bridge adds a third select (Dev2WE/Dev2RD) for this device.

## Test plan
- Reset then read all registers -> CTRL=0, DIV=16, STATUS=0x004, tx=1, IRQ=0.
- DIV=4, CTRL=3, DATA=0xA5:
  - tx low from edge N+1 for 4 cycles;
  - data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high;
  - IRQ rises 41 cycles after N+1.
- DIV=1, five DATA writes back-to-back, EN=0:
  - fifth write sets OVF, STATUS count=4 with FULL;
  - after CTRL=1, four frames of 10 cycles each follow contiguously.
- DIV=0 behaves identically to DIV=1 for byte 0x00 -> a 10-cycle frame with tx low for 9 cycles.
- Mid-frame CTRL=0 at bit 3 -> tx=1 and IDLE next edge, FIFO count=0, no IRQ.
- Assert reset during DATA state -> tx=1 same cycle (async), registers at reset values.
